// File: rtl/sdram_arbit_if.sv
// Bundle of the SDRAM arbiter's request/ack handshakes, per-source command buses
// and the arbitrated SDRAM command bus.
interface sdram_arbit_if;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic [1:0]  init_ba;

  logic        refresh_req, refresh_ack, refresh_end;
  logic [3:0]  ref_cmd;
  logic [12:0] ref_addr;
  logic [1:0]  ref_ba;

  logic        arbit_write_req, arbit_write_ack, write_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_ba;

  logic        arbit_read_req, arbit_read_ack, read_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_ba;

  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank_addr;
  logic        timeout_err;

  modport slave (
    input  init_end, init_cmd, init_addr, init_ba,
    input  refresh_req, refresh_end, ref_cmd, ref_addr, ref_ba,
    input  arbit_write_req, write_end, wr_cmd, wr_addr, wr_ba,
    input  arbit_read_req, read_end, rd_cmd, rd_addr, rd_ba,
    output refresh_ack, arbit_write_ack, arbit_read_ack,
    output sdram_cmd, sdram_addr, sdram_bank_addr, timeout_err
  );

  modport master (
    output init_end, init_cmd, init_addr, init_ba,
    output refresh_req, refresh_end, ref_cmd, ref_addr, ref_ba,
    output arbit_write_req, write_end, wr_cmd, wr_addr, wr_ba,
    output arbit_read_req, read_end, rd_cmd, rd_addr, rd_ba,
    input  refresh_ack, arbit_write_ack, arbit_read_ack,
    input  sdram_cmd, sdram_addr, sdram_bank_addr, timeout_err
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init -> refresh > write/read (alternating), registered command mux,
// one-cycle grant acks and a sticky grant-duration timeout flag.
module sdram_arbit #(
  parameter int TIMEOUT = 1023
) (
  input  logic         sysclk_100M,
  input  logic         rst,
  sdram_arbit_if.slave bus
);

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [9:0] TO  = 10'(TIMEOUT);

  typedef enum logic [4:0] {
    S_INIT    = 5'b00001,
    S_ARBIT   = 5'b00010,
    S_REFRESH = 5'b00100,
    S_WRITE   = 5'b01000,
    S_READ    = 5'b10000
  } state_t;

  state_t      state, nxt;
  logic        last_wr;
  logic [9:0]  gnt_cnt, cnt_nxt;
  logic        in_grant, grant_entry;
  logic        ref_ack, wr_ack, rd_ack, to_err;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;

  always_comb begin
    nxt = state;
    case (state)
      S_INIT:    if (bus.init_end) nxt = S_ARBIT;
      S_ARBIT: begin
        if (bus.refresh_req) nxt = S_REFRESH;
        else if (bus.arbit_write_req && bus.arbit_read_req)
          nxt = last_wr ? S_READ : S_WRITE;
        else if (bus.arbit_write_req) nxt = S_WRITE;
        else if (bus.arbit_read_req)  nxt = S_READ;
      end
      S_REFRESH: if (bus.refresh_end) nxt = S_ARBIT;
      S_WRITE:   if (bus.write_end)   nxt = S_ARBIT;
      S_READ:    if (bus.read_end)    nxt = S_ARBIT;
      default:   nxt = S_INIT;
    endcase
  end

  // Source selected by the current state; registered below for one-cycle latency.
  always_comb begin
    cmd_d  = NOP;
    addr_d = 13'd0;
    ba_d   = 2'd0;
    case (state)
      S_INIT:    begin cmd_d = bus.init_cmd; addr_d = bus.init_addr; ba_d = bus.init_ba; end
      S_REFRESH: begin cmd_d = bus.ref_cmd;  addr_d = bus.ref_addr;  ba_d = bus.ref_ba;  end
      S_WRITE:   begin cmd_d = bus.wr_cmd;   addr_d = bus.wr_addr;   ba_d = bus.wr_ba;   end
      S_READ:    begin cmd_d = bus.rd_cmd;   addr_d = bus.rd_addr;   ba_d = bus.rd_ba;   end
      default:   ;
    endcase
  end

  assign in_grant    = (state == S_REFRESH) || (state == S_WRITE) || (state == S_READ);
  assign grant_entry = (state == S_ARBIT) && (nxt != S_ARBIT);
  assign cnt_nxt     = (gnt_cnt == TO) ? gnt_cnt : gnt_cnt + 10'd1;

  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      state   <= S_INIT;
      last_wr <= 1'b0;
      gnt_cnt <= 10'd0;
      to_err  <= 1'b0;
      ref_ack <= 1'b0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      cmd_q   <= NOP;
      addr_q  <= 13'd0;
      ba_q    <= 2'd0;
    end else begin
      state   <= nxt;
      ref_ack <= grant_entry && (nxt == S_REFRESH);
      wr_ack  <= grant_entry && (nxt == S_WRITE);
      rd_ack  <= grant_entry && (nxt == S_READ);
      if (grant_entry && nxt == S_WRITE)     last_wr <= 1'b1;
      else if (grant_entry && nxt == S_READ) last_wr <= 1'b0;
      // Timeout only flags; the grant continues until its end pulse.
      if (grant_entry) gnt_cnt <= 10'd0;
      else if (in_grant) begin
        gnt_cnt <= cnt_nxt;
        if (cnt_nxt == TO) to_err <= 1'b1;
      end
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
      ba_q   <= ba_d;
    end
  end

  assign bus.refresh_ack     = ref_ack;
  assign bus.arbit_write_ack = wr_ack;
  assign bus.arbit_read_ack  = rd_ack;
  assign bus.sdram_cmd       = cmd_q;
  assign bus.sdram_addr      = addr_q;
  assign bus.sdram_bank_addr = ba_q;
  assign bus.timeout_err     = to_err;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: expected grant order is queued by the stimulus
// and checked by an independent ack monitor; bus values are checked inline.
module tb_sdram_arbit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbit_if bus();
  sdram_arbit #(.TIMEOUT(1023)) dut (.sysclk_100M(clk), .rst(rst), .bus(bus));

  localparam logic [2:0] A_REF = 3'b100, A_WR = 3'b010, A_RD = 3'b001;
  localparam logic [3:0] NOP = 4'b0111;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  wire  [2:0] acks = {bus.refresh_ack, bus.arbit_write_ack, bus.arbit_read_ack};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each ack cycle must match the next queued grant and follow an arbitration (NOP) cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && acks !== 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b expected none", acks);
      end else begin
        chk("ack_order", 32'(acks), 32'(exp_q.pop_front()));
        chk("nop_before_grant", 32'(bus.sdram_cmd), 32'(NOP));
      end
    end
  end

  task automatic wait_any(output logic [2:0] seen);
    seen = 3'b000;
    for (int i = 0; i < 40 && seen == 3'b000; i++) begin
      tick();
      seen = acks;
    end
    checks++;
    if (seen == 3'b000) begin
      errors++;
      $display("FAIL grant_wait: got no ack in 40 cycles expected an ack");
    end
  endtask

  task automatic wait_ack(input logic [2:0] want, input string name);
    logic [2:0] seen;
    wait_any(seen);
    chk(name, 32'(seen), 32'(want));
  endtask

  task automatic pulse_end(input logic [2:0] who);
    case (who)
      A_REF:   bus.refresh_end = 1'b1;
      A_WR:    bus.write_end   = 1'b1;
      A_RD:    bus.read_end    = 1'b1;
      default: ;
    endcase
    tick();
    bus.refresh_end = 1'b0;
    bus.write_end   = 1'b0;
    bus.read_end    = 1'b0;
  endtask

  initial begin
    logic [2:0] seen;
    rst = 1'b1;
    bus.init_end = 1'b0;
    bus.refresh_req = 1'b0; bus.refresh_end = 1'b0;
    bus.arbit_write_req = 1'b0; bus.write_end = 1'b0;
    bus.arbit_read_req = 1'b0;  bus.read_end = 1'b0;
    bus.init_cmd = 4'b0010; bus.init_addr = 13'h0400; bus.init_ba = 2'd3;
    bus.ref_cmd  = 4'b0001; bus.ref_addr  = 13'h0111; bus.ref_ba  = 2'd2;
    bus.wr_cmd   = 4'b0100; bus.wr_addr   = 13'h0405; bus.wr_ba   = 2'd1;
    bus.rd_cmd   = 4'b0101; bus.rd_addr   = 13'h0222; bus.rd_ba   = 2'd0;
    tick(); tick();
    chk("rst_cmd", 32'(bus.sdram_cmd), 32'(NOP));
    chk("rst_addr", 32'(bus.sdram_addr), 32'h0);
    chk("rst_ba", 32'(bus.sdram_bank_addr), 32'h0);
    chk("rst_acks", 32'(acks), 32'h0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'h0);

    // Init passthrough, then write requested alongside init_end.
    rst = 1'b0;
    tick();
    chk("init_cmd", 32'(bus.sdram_cmd), 32'h2);
    chk("init_addr", 32'(bus.sdram_addr), 32'h0400);
    bus.init_end = 1'b1; bus.arbit_write_req = 1'b1; exp_q.push_back(A_WR);
    tick();
    chk("no_ack_in_init", 32'(acks), 32'h0);
    wait_ack(A_WR, "first_write");
    bus.arbit_write_req = 1'b0;
    tick();
    chk("wr_cmd", 32'(bus.sdram_cmd), 32'h4);
    chk("wr_addr", 32'(bus.sdram_addr), 32'h0405);
    chk("wr_ba", 32'(bus.sdram_bank_addr), 32'h1);
    // Foreign sources and foreign end pulses must not disturb the write grant.
    bus.rd_cmd = 4'b0110; bus.rd_addr = 13'h1abc; bus.ref_cmd = 4'b0011; bus.ref_addr = 13'h0777;
    pulse_end(A_RD);
    pulse_end(A_REF);
    chk("wr_hold_cmd", 32'(bus.sdram_cmd), 32'h4);
    chk("wr_hold_addr", 32'(bus.sdram_addr), 32'h0405);
    chk("wr_hold_ba", 32'(bus.sdram_bank_addr), 32'h1);
    bus.rd_cmd = 4'b0101; bus.rd_addr = 13'h0222; bus.ref_cmd = 4'b0001; bus.ref_addr = 13'h0111;
    pulse_end(A_WR);
    tick();
    chk("arbit_nop", 32'(bus.sdram_cmd), 32'(NOP));

    // Lone read leaves last_wr = 0.
    bus.arbit_read_req = 1'b1; exp_q.push_back(A_RD);
    wait_ack(A_RD, "lone_read");
    bus.arbit_read_req = 1'b0;
    tick();
    chk("rd_cmd", 32'(bus.sdram_cmd), 32'h5);
    chk("rd_addr", 32'(bus.sdram_addr), 32'h0222);
    pulse_end(A_RD);

    // All three pending: refresh, then write, then read.
    bus.refresh_req = 1'b1; bus.arbit_write_req = 1'b1; bus.arbit_read_req = 1'b1;
    exp_q.push_back(A_REF); exp_q.push_back(A_WR); exp_q.push_back(A_RD);
    wait_ack(A_REF, "prio_ref");
    bus.refresh_req = 1'b0;
    tick();
    chk("ref_cmd", 32'(bus.sdram_cmd), 32'h1);
    chk("ref_ba", 32'(bus.sdram_bank_addr), 32'h2);
    pulse_end(A_REF);
    wait_ack(A_WR, "prio_wr");
    bus.arbit_write_req = 1'b0;
    pulse_end(A_WR);
    wait_ack(A_RD, "prio_rd");
    bus.arbit_read_req = 1'b0;
    pulse_end(A_RD);

    // Write and read held: W,R,W alternate; refresh raised during the 2nd write cuts in.
    bus.arbit_write_req = 1'b1; bus.arbit_read_req = 1'b1;
    exp_q.push_back(A_WR); exp_q.push_back(A_RD); exp_q.push_back(A_WR);
    for (int g = 0; g < 5; g++) begin
      wait_any(seen);
      if (g == 2) begin
        bus.refresh_req = 1'b1;
        exp_q.push_back(A_REF); exp_q.push_back(A_RD);
      end
      if (seen == A_REF) bus.refresh_req = 1'b0;
      if (g == 4) begin bus.arbit_write_req = 1'b0; bus.arbit_read_req = 1'b0; end
      tick(); tick();
      pulse_end(seen);
    end
    tick(); tick();

    // Grant held past TIMEOUT cycles.
    bus.arbit_write_req = 1'b1; exp_q.push_back(A_WR);
    wait_ack(A_WR, "timeout_write");
    bus.arbit_write_req = 1'b0;
    repeat (1022) tick();
    chk("timeout_before", 32'(bus.timeout_err), 32'h0);
    tick();
    chk("timeout_set", 32'(bus.timeout_err), 32'h1);
    chk("timeout_still_wr", 32'(bus.sdram_cmd), 32'h4);
    pulse_end(A_WR);
    tick();
    chk("timeout_end_nop", 32'(bus.sdram_cmd), 32'(NOP));
    chk("timeout_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset mid-read, then re-init with the read still requested.
    bus.arbit_read_req = 1'b1; exp_q.push_back(A_RD);
    wait_ack(A_RD, "pre_reset_read");
    tick();
    chk("mid_read_cmd", 32'(bus.sdram_cmd), 32'h5);
    rst = 1'b1; bus.init_end = 1'b0;
    tick();
    chk("rst_mid_cmd", 32'(bus.sdram_cmd), 32'(NOP));
    chk("rst_mid_acks", 32'(acks), 32'h0);
    chk("rst_mid_timeout", 32'(bus.timeout_err), 32'h0);
    chk("rst_mid_addr", 32'(bus.sdram_addr), 32'h0);
    rst = 1'b0;
    tick();
    chk("reinit_cmd", 32'(bus.sdram_cmd), 32'h2);
    repeat (3) tick();
    chk("reinit_hold", 32'(bus.sdram_cmd), 32'h2);
    exp_q.push_back(A_RD);
    bus.init_end = 1'b1;
    wait_ack(A_RD, "post_init_read");
    bus.arbit_read_req = 1'b0;
    pulse_end(A_RD);
    tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
